// File: rtl/usb_fifo_pkg.sv
// Shared types and constants for the USB FT245-style FIFO bridge.
package usb_fifo_pkg;
    localparam int USB_DATA_W = 8;

    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_OE = 3'd1,
        RD    = 3'd2,
        WR    = 3'd3,
        TURN  = 3'd4
    } usb_state_t;
endpackage

// File: rtl/usb_stream_fifo.sv
// First-word-fall-through synchronous FIFO with valid/ready ports and an occupancy count.
module usb_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [WIDTH-1:0]       i_in_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [WIDTH-1:0]       o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_in_ready  = (r_level != (AW+1)'(DEPTH));
    assign o_out_valid = (r_level != '0);
    assign o_out_data  = r_mem[r_rd_ptr];
    assign o_level     = r_level;
    assign w_push      = i_in_valid && o_in_ready;
    assign w_pop       = i_out_ready && o_out_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push)
            r_mem[r_wr_ptr] <= i_in_data;
    end

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end
endmodule

// File: rtl/usb_fifo_bridge.sv
// FT245 sync-FIFO bridge: RX/TX buffers plus a burst-limited direction arbiter.
// Define USB_LOOPBACK_EN to echo host data back internally (external streams idle).
module usb_fifo_bridge
    import usb_fifo_pkg::*;
#(
    parameter int RX_DEPTH     = 512,
    parameter int TX_DEPTH     = 512,
    parameter int RX_AF_MARGIN = 4,
    parameter int MAX_BURST    = 64
) (
    input  logic                      i_usb_clk_60m,
    input  logic                      i_sys_rst_n,
    input  logic                      i_usb_rxf_n,
    input  logic                      i_usb_txe_n,
    output logic                      o_usb_oe_n,
    output logic                      o_usb_rd_n,
    output logic                      o_usb_wr_n,
    inout  wire  [USB_DATA_W-1:0]     io_usb_data,
    output logic                      o_usb_siwu_n,
    output logic [USB_DATA_W-1:0]     o_rx_data,
    output logic                      o_rx_valid,
    input  logic                      i_rx_ready,
    input  logic [USB_DATA_W-1:0]     i_tx_data,
    input  logic                      i_tx_valid,
    output logic                      o_tx_ready,
    output logic [$clog2(RX_DEPTH):0] o_rx_level,
    output logic [$clog2(TX_DEPTH):0] o_tx_level,
    output logic                      o_rx_overrun
);
    localparam int RLW = $clog2(RX_DEPTH) + 1;
    localparam int TLW = $clog2(TX_DEPTH) + 1;
    localparam int BW  = $clog2(MAX_BURST + 1);

    usb_state_t          r_state;
    logic                r_oe_n;
    logic                r_rd_n;
    logic                r_last_dir;
    logic [BW-1:0]       r_burst;
    logic                r_overrun;

    logic                  w_rx_in_ready;
    logic [USB_DATA_W-1:0] w_rx_head;
    logic                  w_rx_head_valid;
    logic                  w_rx_pop_rdy;
    logic [USB_DATA_W-1:0] w_tx_in_data;
    logic                  w_tx_in_valid;
    logic                  w_tx_in_ready;
    logic [USB_DATA_W-1:0] w_tx_head;
    logic                  w_tx_head_valid;
    logic [RLW-1:0]        w_rx_level;
    logic [TLW-1:0]        w_tx_level;
    logic [RLW-1:0]        w_rx_free;
    logic [RLW-1:0]        w_rx_free_nxt;
    logic [TLW-1:0]        w_tx_level_nxt;
    logic [BW-1:0]         w_burst_nxt;
    logic                  w_rx_cap;
    logic                  w_tx_pop;
    logic                  w_tx_push;
    logic                  w_rx_req;
    logic                  w_tx_req;
    logic                  w_unused_lb;

    usb_stream_fifo #(.WIDTH(USB_DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .i_clk       (i_usb_clk_60m),
        .i_rst_n     (i_sys_rst_n),
        .i_in_data   (io_usb_data),
        .i_in_valid  (w_rx_cap),
        .o_in_ready  (w_rx_in_ready),
        .o_out_data  (w_rx_head),
        .o_out_valid (w_rx_head_valid),
        .i_out_ready (w_rx_pop_rdy),
        .o_level     (w_rx_level)
    );

    usb_stream_fifo #(.WIDTH(USB_DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .i_clk       (i_usb_clk_60m),
        .i_rst_n     (i_sys_rst_n),
        .i_in_data   (w_tx_in_data),
        .i_in_valid  (w_tx_in_valid),
        .o_in_ready  (w_tx_in_ready),
        .o_out_data  (w_tx_head),
        .o_out_valid (w_tx_head_valid),
        .i_out_ready (w_tx_pop),
        .o_level     (w_tx_level)
    );

`ifdef USB_LOOPBACK_EN
    assign w_rx_pop_rdy  = w_tx_in_ready;
    assign w_tx_in_valid = w_rx_head_valid;
    assign w_tx_in_data  = w_rx_head;
    assign o_rx_valid    = 1'b0;
    assign o_rx_data     = '0;
    assign o_tx_ready    = 1'b0;
    assign w_unused_lb   = ^{i_tx_data, i_tx_valid, i_rx_ready, w_tx_head_valid};
`else
    assign w_rx_pop_rdy  = i_rx_ready;
    assign w_tx_in_valid = i_tx_valid;
    assign w_tx_in_data  = i_tx_data;
    assign o_rx_valid    = w_rx_head_valid;
    assign o_rx_data     = w_rx_head;
    assign o_tx_ready    = w_tx_in_ready;
    assign w_unused_lb   = w_tx_head_valid;
`endif

    assign o_usb_oe_n   = r_oe_n;
    assign o_usb_rd_n   = r_rd_n;
    assign o_usb_wr_n   = !((r_state == WR) && (w_tx_level != '0));
    assign o_usb_siwu_n = 1'b1;
    assign o_rx_level   = w_rx_level;
    assign o_tx_level   = w_tx_level;
    assign o_rx_overrun = r_overrun;
    assign io_usb_data  = (r_state == WR) ? w_tx_head : {USB_DATA_W{1'bz}};

    assign w_rx_cap       = (r_state == RD) && !i_usb_rxf_n;
    assign w_tx_pop       = !o_usb_wr_n && !i_usb_txe_n;
    assign w_tx_push      = w_tx_in_valid && w_tx_in_ready;
    assign w_rx_free      = RLW'(RX_DEPTH) - w_rx_level;
    // Consumer pops are ignored here so the stop point is conservative.
    assign w_rx_free_nxt  = w_rx_free - RLW'(w_rx_cap);
    assign w_tx_level_nxt = w_tx_level - TLW'(w_tx_pop) + TLW'(w_tx_push);
    assign w_burst_nxt    = r_burst + BW'(w_rx_cap | w_tx_pop);
    assign w_rx_req       = !i_usb_rxf_n && (w_rx_free > RLW'(RX_AF_MARGIN));
    assign w_tx_req       = !i_usb_txe_n && (w_tx_level != '0);

    always_ff @(posedge i_usb_clk_60m) begin
        if (!i_sys_rst_n) begin
            r_state    <= IDLE;
            r_oe_n     <= 1'b1;
            r_rd_n     <= 1'b1;
            r_last_dir <= DIR_TX;
            r_burst    <= '0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_rx_cap && !w_rx_in_ready) r_overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_rx_req && (!w_tx_req || r_last_dir == DIR_TX)) begin
                        r_state <= RD_OE;
                        r_oe_n  <= 1'b0;
                    end else if (w_tx_req) begin
                        r_state <= WR;
                    end
                end
                RD_OE: begin
                    r_state <= RD;
                    r_rd_n  <= 1'b0;
                end
                RD: begin
                    r_burst <= w_burst_nxt;
                    if (i_usb_rxf_n || w_rx_free_nxt <= RLW'(RX_AF_MARGIN) ||
                        w_burst_nxt == BW'(MAX_BURST)) begin
                        r_state    <= TURN;
                        r_oe_n     <= 1'b1;
                        r_rd_n     <= 1'b1;
                        r_last_dir <= DIR_RX;
                    end
                end
                WR: begin
                    r_burst <= w_burst_nxt;
                    if (i_usb_txe_n || w_tx_level_nxt == '0 ||
                        w_burst_nxt == BW'(MAX_BURST)) begin
                        r_state    <= TURN;
                        r_last_dir <= DIR_TX;
                    end
                end
                TURN: begin
                    r_burst <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_fifo_bridge.sv
// Directed bench for usb_fifo_bridge with a behavioural FT245 chip model.
module tb_usb_fifo_bridge;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxf_n, txe_n, oe_n, rd_n, wr_n, siwu_n;
    wire  [7:0] usb_data;
    logic [7:0] rx_data, tx_data;
    logic       rx_valid, rx_ready, tx_valid, tx_ready, rx_overrun;
    logic [4:0] rx_level, tx_level;

    always #8 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Chip model state.
    logic [7:0] rx_mem [64];
    int         rx_cnt;
    int         rx_idx = 0;
    logic       rxf_force, txe_force, tog_en;
    int         tog_base;
    int         hold = 0;
    logic [7:0] tx_log [64];
    int         tx_n = 0;
    logic [7:0] rx_log [128];
    int         rx_n = 0;
    logic       run_dir [128];
    int         run_len [128];
    int         run_n = 0;
    int         cur_len = 0;
    logic       cur_dir = 1'b0;
    logic       prev_oe_low = 1'b0, prev_wr_low = 1'b0, contention = 1'b0;
    logic       rx_acc, tx_acc;

    assign rxf_n    = rxf_force || (rx_idx >= rx_cnt);
    assign txe_n    = txe_force || (hold != 0);
    assign usb_data = !oe_n ? rx_mem[rx_idx[5:0]] : 8'bz;
    assign rx_acc   = !rd_n && !rxf_n;
    assign tx_acc   = !wr_n && !txe_n;

    usb_fifo_bridge #(.RX_DEPTH(16), .TX_DEPTH(16), .RX_AF_MARGIN(4), .MAX_BURST(4)) dut (
        .i_usb_clk_60m (clk),
        .i_sys_rst_n   (rst_n),
        .i_usb_rxf_n   (rxf_n),
        .i_usb_txe_n   (txe_n),
        .o_usb_oe_n    (oe_n),
        .o_usb_rd_n    (rd_n),
        .o_usb_wr_n    (wr_n),
        .io_usb_data   (usb_data),
        .o_usb_siwu_n  (siwu_n),
        .o_rx_data     (rx_data),
        .o_rx_valid    (rx_valid),
        .i_rx_ready    (rx_ready),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid),
        .o_tx_ready    (tx_ready),
        .o_rx_level    (rx_level),
        .o_tx_level    (tx_level),
        .o_rx_overrun  (rx_overrun)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (rx_acc) rx_idx <= rx_idx + 1;
            if (tx_acc) begin
                tx_log[tx_n] <= usb_data;
                tx_n <= tx_n + 1;
                if (tog_en && (tx_n - tog_base == 2)) hold <= 5;
            end else if (hold != 0) begin
                hold <= hold - 1;
            end
            if (rx_valid && rx_ready) begin
                rx_log[rx_n] <= rx_data;
                rx_n <= rx_n + 1;
            end
            if (rx_acc || tx_acc) begin
                cur_len <= cur_len + 1;
                cur_dir <= tx_acc;
            end else if (cur_len != 0) begin
                run_dir[run_n] <= cur_dir;
                run_len[run_n] <= cur_len;
                run_n   <= run_n + 1;
                cur_len <= 0;
            end
            if ((!oe_n && !wr_n) || (rx_acc && tx_acc) ||
                (prev_oe_low && !wr_n) || (prev_wr_low && !oe_n))
                contention <= 1'b1;
            prev_oe_low <= !oe_n;
            prev_wr_low <= !wr_n;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int base_run, base_tx;
        rst_n = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        rxf_force = 1'b0; txe_force = 1'b0; tog_en = 1'b0; tog_base = 0;
        for (int i = 0; i < 16; i++) rx_mem[i] = 8'(i);
        for (int i = 0; i < 40; i++) rx_mem[16+i] = 8'(8'h40 + i);
        for (int i = 0; i < 8; i++)  rx_mem[56+i] = 8'(8'hC0 + i);
`ifdef USB_LOOPBACK_EN
        rx_mem[0] = 8'h55; rx_mem[1] = 8'hAA; rx_mem[2] = 8'h01;
        rx_cnt = 3;
`else
        rx_cnt = 16;
`endif
        // Reset with chip data pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_rd_n", rd_n, 1);
        chk("rst_wr_n", wr_n, 1);
        chk("rst_siwu_n", siwu_n, 1);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", rx_overrun, 0);
`ifdef USB_LOOPBACK_EN
        chk("rst_tx_ready_lb", tx_ready, 0);
        rst_n = 1'b1;
        for (int c = 0; c < 300 && tx_n < 3; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("lb_count", tx_n, 3);
        chk("lb_b0", tx_log[0], 8'h55);
        chk("lb_b1", tx_log[1], 8'hAA);
        chk("lb_b2", tx_log[2], 8'h01);
        chk("lb_rx_valid", rx_valid, 0);
        chk("lb_tx_ready", tx_ready, 0);
        chk("lb_contention", contention, 0);
`else
        chk("rst_tx_ready", tx_ready, 1);
        rx_ready = 1'b1;
        rst_n = 1'b1;

        // RX burst 0x00..0x0F.
        for (int c = 0; c < 300 && rx_n < 16; c++) @(negedge clk);
        chk("rxb_count", rx_n, 16);
        for (int i = 0; i < 16; i++) chk("rxb_byte", rx_log[i], i);
        chk("rxb_overrun", rx_overrun, 0);

        // Backpressure: reads must stall with 4 free slots.
        rx_ready = 1'b0;
        rx_cnt = 56;
        repeat (80) @(negedge clk);
        chk("bp_level", rx_level, 12);
        chk("bp_chip_idx", rx_idx, 28);
        chk("bp_rd_n", rd_n, 1);
        chk("bp_rx_valid", rx_valid, 1);
        chk("bp_head", rx_data, 8'h40);
        chk("bp_overrun", rx_overrun, 0);
        rx_ready = 1'b1;
        for (int c = 0; c < 600 && rx_n < 56; c++) @(negedge clk);
        chk("bp_count", rx_n, 56);
        for (int i = 0; i < 40; i++) chk("bp_byte", rx_log[16+i], 8'h40 + i);
        chk("bp_overrun_end", rx_overrun, 0);

        // TX with txe_n held high for 5 cycles after the 3rd accept.
        tog_base = tx_n;
        tog_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_ready", tx_ready, 1);
            tx_data = 8'(8'hA0 + i);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        for (int c = 0; c < 300 && tx_n < tog_base + 8; c++) @(negedge clk);
        repeat (20) @(negedge clk);
        chk("txt_count", tx_n - tog_base, 8);
        for (int i = 0; i < 8; i++) chk("txt_byte", tx_log[tog_base+i], 8'hA0 + i);
        chk("txt_level", tx_level, 0);
        tog_en = 1'b0;

        // Arbitration: both directions pending, bursts of 4 alternate starting with RX.
        rxf_force = 1'b1;
        txe_force = 1'b1;
        rx_cnt = 64;
        for (int i = 0; i < 8; i++) begin
            tx_data = 8'(8'hB0 + i);
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("arb_preload", tx_level, 8);
        base_run = run_n;
        base_tx = tx_n;
        rxf_force = 1'b0;
        txe_force = 1'b0;
        for (int c = 0; c < 300 && (run_n < base_run + 4 || rx_n < 64); c++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("arb_runs", run_n - base_run, 4);
        for (int i = 0; i < 4; i++) begin
            chk("arb_dir", run_dir[base_run+i], i % 2);
            chk("arb_len", run_len[base_run+i], 4);
        end
        for (int i = 0; i < 8; i++) chk("arb_tx_byte", tx_log[base_tx+i], 8'hB0 + i);
        for (int i = 0; i < 8; i++) chk("arb_rx_byte", rx_log[56+i], 8'hC0 + i);
        chk("arb_contention", contention, 0);
        chk("arb_overrun", rx_overrun, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
